mcs4_clkgen: RTL

MCS4_CLKGEN -- requirements
Module: mcs4_clkgen

---
 rtl/mcs4_pkg.sv | 18 +
 rtl/mcs4_poc_counter.sv | 34 +++
 rtl/mcs4_clkgen.sv | 118 +++++++++++
 3 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 timing constants: machine-clock indices and quarter-phase codes.
package mcs4_pkg;

    localparam logic [2:0] A1 = 3'd0;
    localparam logic [2:0] A2 = 3'd1;
    localparam logic [2:0] A3 = 3'd2;
    localparam logic [2:0] M1 = 3'd3;
    localparam logic [2:0] M2 = 3'd4;
    localparam logic [2:0] X1 = 3'd5;
    localparam logic [2:0] X2 = 3'd6;
    localparam logic [2:0] X3 = 3'd7;

    localparam logic [1:0] Q_CLK1 = 2'd0;
    localparam logic [1:0] Q_GAP1 = 2'd1;
    localparam logic [1:0] Q_CLK2 = 2'd2;
    localparam logic [1:0] Q_GAP2 = 2'd3;

endpackage

// File: rtl/mcs4_poc_counter.sv
// Power-on-clear: holds poc high until POC_CYCLES instruction cycles complete.
module mcs4_poc_counter #(
    parameter int POC_CYCLES = 16
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic wrap_i,
    output logic poc_o
);

    localparam logic [7:0] POC_N = 8'(POC_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       poc_q;

    // Saturating count keeps poc low until the next reset.
    always_comb begin
        cnt_d = cnt_q;
        if (wrap_i && (cnt_q != POC_N)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            cnt_q <= '0;
            poc_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            poc_q <= (cnt_q != POC_N);
        end
    end

    assign poc_o = poc_q;

endmodule

// File: rtl/mcs4_clkgen.sv
// MCS-4 two-phase bus clock, sync and power-on-clear generator.
// Define MCS4_CLKGEN_STEP_EN to add run/step halting at the instruction boundary.
module mcs4_clkgen
    import mcs4_pkg::*;
#(
    parameter int PHASE_LEN  = 4,
    parameter int POC_CYCLES = 16
) (
    input  logic       sysclk,
    input  logic       sysrst_n,
    input  logic       run,
    input  logic       step,
    output logic       clk1_pad,
    output logic       clk2_pad,
    output logic       sync_pad,
    output logic       poc_pad,
    output logic [2:0] cycle,
    output logic       halted
);

    localparam logic [7:0] P_LAST = 8'(PHASE_LEN - 1);

    logic [7:0] p_q, p_d;
    logic [1:0] q_q, q_d;
    logic [2:0] c_q, c_d;
    logic       hold_q;
    logic       last_tick;

    logic       clk1_q, clk2_q, sync_q;
    logic [2:0] cycle_q;

    assign last_tick = (c_q == X3) && (q_q == Q_GAP2) && (p_q == P_LAST);

    // q and c wrap by natural overflow of their 2- and 3-bit widths.
    always_comb begin
        p_d = p_q + 8'd1;
        q_d = q_q;
        c_d = c_q;
        if (p_q == P_LAST) begin
            p_d = '0;
            q_d = q_q + 2'd1;
            if (q_q == Q_GAP2) c_d = c_q + 3'd1;
        end
        if (hold_q) begin
            p_d = p_q;
            q_d = q_q;
            c_d = c_q;
        end
    end

`ifdef MCS4_CLKGEN_STEP_EN
    logic hold_d, step_q, step_rise, halted_q;

    assign step_rise = step & ~step_q;

    // Step edges only matter while frozen, so mid-cycle pulses fall through.
    always_comb begin
        hold_d = hold_q;
        if (hold_q)                 hold_d = ~(run | step_rise);
        else if (last_tick && !run) hold_d = 1'b1;
    end

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            hold_q   <= 1'b0;
            step_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            step_q   <= step;
            halted_q <= hold_q;
        end
    end

    assign halted = halted_q;
`else
    logic unused_inputs;

    assign unused_inputs = run ^ step;
    assign hold_q        = 1'b0;
    assign halted        = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            p_q     <= '0;
            q_q     <= Q_CLK1;
            c_q     <= A1;
            clk1_q  <= 1'b0;
            clk2_q  <= 1'b0;
            sync_q  <= 1'b0;
            cycle_q <= A1;
        end else begin
            p_q     <= p_d;
            q_q     <= q_d;
            c_q     <= c_d;
            clk1_q  <= (q_q == Q_CLK1) && !hold_q;
            clk2_q  <= (q_q == Q_CLK2) && !hold_q;
            sync_q  <= (c_q == X3) && !hold_q;
            cycle_q <= c_q;
        end
    end

    mcs4_poc_counter #(
        .POC_CYCLES (POC_CYCLES)
    ) u_poc (
        .sysclk   (sysclk),
        .sysrst_n (sysrst_n),
        .wrap_i   (last_tick),
        .poc_o    (poc_pad)
    );

    assign clk1_pad = clk1_q;
    assign clk2_pad = clk2_q;
    assign sync_pad = sync_q;
    assign cycle    = cycle_q;

endmodule
